sao_stat_bo_accum: RTL
======================

Name: sao_stat_bo_accum

Overview:
- Per-CTB band-offset statistics accumulator. It is the receiving end of the 4-pixel BO partial-sum adder.
- Each beat it takes the four merged partial sums (s41/s31/s21/s11), the band categories and the use mask, and accumulates per-band diff sums and pixel counts for the 32 bands.
- At CTB end it streams the 32 (band, sum, count) tuples to the offset-decision stage over a valid/ready interface.

Parameters:
- diff_clip_bit, 4, diff magnitude bits. Input sums are signed, widths diff_clip_bit+1..+3.
- n_pix, 4, pixels per beat. Fixed at 4.
- n_bo_type, 5, band index width; 2^n_bo_type = 32 bands.
- sum_w, 18, accumulator sum width, signed (diff_clip_bit+14; covers 4096 px at max diff).
- cnt_w, 13, per-band pixel count width, unsigned (max 4096).

Ports:
- clk, input, 1, clock.
- arst_n, input, 1, asynchronous active-low reset.
- ctb_start, input, 1, pulse: clear all accumulators and enter ACC.
- in_valid, input, 1, a beat is present on the sum/category inputs.
- ctb_end, input, 1, qualifies the current in_valid beat as the last beat of the CTB.
- s41, input, diff_clip_bit+3, signed; pixel-0-band sum over pixels 0..3.
- s31, input, diff_clip_bit+3, signed; pixel-1-band sum over pixels 1..3.
- s21, input, diff_clip_bit+2, signed; pixel-2-band sum over pixels 2..3.
- s11, input, diff_clip_bit+1, signed; pixel-3 diff.
- bo_cate[0:3], input, n_bo_type each, band of each pixel, aligned to the sums.
- b_use, input, 4, per-pixel use mask, aligned to the sums.
- rd_valid, output, 1, readout tuple valid.
- rd_ready, input, 1, downstream accepts the tuple.
- rd_band, output, n_bo_type, band index of the current tuple.
- rd_sum, output, sum_w, signed band sum.
- rd_cnt, output, cnt_w, band pixel count.
- ctb_done, output, 1, one-cycle pulse when band 31 is accepted.
- busy, output, 1, high in ACC or READ.

Behaviour:
- Reset (arst_n low): state IDLE. All accumulators 0, rd_valid=0, rd_band=0, rd_sum=0, rd_cnt=0, ctb_done=0, busy=0.
- FSM states IDLE, ACC, READ.
  - IDLE -> ACC on ctb_start.
  - ACC -> READ on in_valid & ctb_end.
  - READ -> IDLE when band 31 is handshaken (rd_valid & rd_ready).
  - ctb_start in any state forces ACC and clears all accumulators. This aborts any readout; no ctb_done is issued for the aborted CTB.
- Accumulation applies only in ACC with in_valid. For pixel k in 0..3, the write is enabled if no j<k has bo_cate[j]==bo_cate[k]. This first-occurrence rule gives at most 4 distinct bands per beat, so there are no write conflicts.
  - Sum update: acc_sum[bo_cate[k]] += sign-extended s(4-k)1, i.e. k=0 -> s41, k=1 -> s31, k=2 -> s21, k=3 -> s11.
  - Count update: acc_cnt[bo_cate[k]] += popcount of b_use[m] over m>=k with bo_cate[m]==bo_cate[k]. A count increment of 0 is legal.
  - Sum and count are updated under the same enable even when the increment is zero.
  - Sum wraps modulo 2^sum_w; the count saturates at 2^cnt_w-1. Neither is reachable in spec-legal CTBs.
  - Results are visible in the accumulators on the cycle after the beat.
- ctb_start together with in_valid in the same cycle: the clear takes priority, and this beat's increments are then written as the first data (accumulator = increment).
- in_valid outside ACC is ignored, with no state change. ctb_end without in_valid is ignored.
- READ:
  - The cycle after entering READ, rd_valid=1 with rd_band=0 and that band's sum and count.
  - On rd_valid & rd_ready, rd_band increments and the next tuple appears in the following cycle. Back-to-back transfers are allowed: one tuple per cycle while rd_ready stays high.
  - With rd_ready low, all rd_* outputs are held stable.
  - After band 31 is accepted: ctb_done=1 for one cycle, rd_valid=0, state IDLE.
  - Accumulators keep their values until the next ctb_start.
- busy=1 in ACC and READ.
- rd_sum and rd_cnt are registered outputs, driven 0 when rd_valid=0.

Test Plan:
1. All four pixels in band 7, b_use=1111, s41=+6 (s31/s21/s11 ignored), with ctb_end on that beat -> readout band 7 gives sum=6, cnt=4; every other band gives sum=0, cnt=0; ctb_done pulses after exactly 32 accepts with rd_ready=1.
2. Four beats of distinct bands {0,1,2,3}, b_use=1111, sums s41=-1, s31=2, s21=-3, s11=4 each beat -> bands 0..3 give sums -4, 8, -12, 16, each with cnt=4.
3. Bands {5,9,5,9}, b_use=1011, s41=3, s31=-2 -> band 5 gives sum=3, cnt=1 (pixel 2 masked); band 9 gives sum=-2, cnt=2.
4. rd_ready toggles 1,0,0,1 during READ -> band 0 accepted; band 1 held stable for two cycles and then accepted; no band skipped or duplicated.
5. ctb_start asserted at band 10 of a readout together with in_valid, bands {2,2,2,2}, s41=5, b_use=1111 -> no ctb_done; state ACC; after a subsequent end beat, band 2 gives sum=5, cnt=4 and all other bands give 0.
6. arst_n asserted mid-ACC and mid-READ -> outputs immediately 0, state IDLE; in_valid ignored until the next ctb_start.

Source files
------------

// File: rtl/sao_stat_bo_accum.sv
// ---------------------------------------------------------------------------
// sao_stat_bo_accum
// Per-CTB band-offset statistics accumulator. Collects, for each of the 32
// SAO bands, the signed sum of pixel differences and the number of pixels
// that fell into the band. At the end of a CTB the 32 (band, sum, count)
// tuples are streamed out over a valid/ready interface.
// ---------------------------------------------------------------------------
module sao_stat_bo_accum #(
   parameter int diff_clip_bit = 4,
   parameter int n_pix         = 4,
   parameter int n_bo_type     = 5,
   parameter int sum_w         = 18,
   parameter int cnt_w         = 13
) (
   input  logic                           clk,
   input  logic                           arst_n,
   input  logic                           ctb_start,
   input  logic                           in_valid,
   input  logic                           ctb_end,
   input  logic signed [diff_clip_bit+2:0] s41,
   input  logic signed [diff_clip_bit+2:0] s31,
   input  logic signed [diff_clip_bit+1:0] s21,
   input  logic signed [diff_clip_bit:0]   s11,
   input  logic [n_bo_type-1:0]           bo_cate [0:n_pix-1],
   input  logic [n_pix-1:0]               b_use,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic [n_bo_type-1:0]           rd_band,
   output logic signed [sum_w-1:0]        rd_sum,
   output logic [cnt_w-1:0]               rd_cnt,
   output logic                           ctb_done,
   output logic                           busy
);

   localparam int n_band    = 1 << n_bo_type;
   localparam int w41       = diff_clip_bit + 3;
   localparam int w21       = diff_clip_bit + 2;
   localparam int w11       = diff_clip_bit + 1;
   localparam int inc_w     = $clog2(n_pix + 1);
   localparam int cnt_x_w   = cnt_w + 1;
   localparam logic [n_bo_type-1:0] last_band = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      READ
   } state_t;

   state_t state;

   logic signed [sum_w-1:0] acc_sum [0:n_band-1];
   logic [cnt_w-1:0]        acc_cnt [0:n_band-1];
   logic signed [sum_w-1:0] nxt_sum [0:n_band-1];
   logic [cnt_w-1:0]        nxt_cnt [0:n_band-1];

   logic signed [sum_w-1:0] inc_sum [0:n_pix-1];
   logic [inc_w-1:0]        inc_cnt [0:n_pix-1];
   logic [n_pix-1:0]        wr_en;
   logic                    do_acc;
   logic [cnt_w:0]          cnt_ext;
   logic [n_bo_type-1:0]    nxt_band;

   assign nxt_band = rd_band + n_bo_type'(1);

   // Per-pixel increments: only the first pixel of each band in the beat
   // writes, carrying its merged partial sum and the used-pixel count of
   // every later pixel sharing the band.
   always_comb begin
      inc_sum[0] = {{(sum_w-w41){s41[w41-1]}}, s41};
      inc_sum[1] = {{(sum_w-w41){s31[w41-1]}}, s31};
      inc_sum[2] = {{(sum_w-w21){s21[w21-1]}}, s21};
      inc_sum[3] = {{(sum_w-w11){s11[w11-1]}}, s11};
      for (int k = 0; k < n_pix; k++) begin
         wr_en[k]   = 1'b1;
         inc_cnt[k] = '0;
         for (int j = 0; j < n_pix; j++) begin
            if (j < k && bo_cate[j] == bo_cate[k]) begin
               wr_en[k] = 1'b0;
            end
            if (j >= k && bo_cate[j] == bo_cate[k] && b_use[j]) begin
               inc_cnt[k] = inc_cnt[k] + inc_w'(1);
            end
         end
      end
   end

   // Next accumulator contents: a start clears everything, then this beat's
   // increments (if accepted) land on top; counts saturate, sums wrap.
   always_comb begin
      do_acc  = in_valid && (ctb_start || state == ACC);
      cnt_ext = '0;
      for (int b = 0; b < n_band; b++) begin
         nxt_sum[b] = ctb_start ? '0 : acc_sum[b];
         nxt_cnt[b] = ctb_start ? '0 : acc_cnt[b];
      end
      if (do_acc) begin
         for (int k = 0; k < n_pix; k++) begin
            if (wr_en[k]) begin
               nxt_sum[bo_cate[k]] = nxt_sum[bo_cate[k]] + inc_sum[k];
               cnt_ext = {1'b0, nxt_cnt[bo_cate[k]]} + cnt_x_w'(inc_cnt[k]);
               nxt_cnt[bo_cate[k]] = cnt_ext[cnt_w] ? '1 : cnt_ext[cnt_w-1:0];
            end
         end
      end
   end

   // Accumulator bank register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int b = 0; b < n_band; b++) begin
            acc_sum[b] <= '0;
            acc_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < n_band; b++) begin
            acc_sum[b] <= nxt_sum[b];
            acc_cnt[b] <= nxt_cnt[b];
         end
      end
   end

   // Control FSM with registered readout outputs; ctb_start overrides
   // everything, including an in-progress readout.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= IDLE;
         rd_valid <= 1'b0;
         rd_band  <= '0;
         rd_sum   <= '0;
         rd_cnt   <= '0;
         ctb_done <= 1'b0;
         busy     <= 1'b0;
      end else begin
         ctb_done <= 1'b0;
         if (ctb_start) begin
            state    <= ACC;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_band  <= '0;
            rd_sum   <= '0;
            rd_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  busy <= 1'b0;
               end
               ACC: begin
                  if (in_valid && ctb_end) begin
                     state   <= READ;
                     rd_band <= '0;
                  end
               end
               READ: begin
                  if (!rd_valid) begin
                     rd_valid <= 1'b1;
                     rd_sum   <= acc_sum[rd_band];
                     rd_cnt   <= acc_cnt[rd_band];
                  end else if (rd_ready) begin
                     if (rd_band == last_band) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rd_valid <= 1'b0;
                        rd_band  <= '0;
                        rd_sum   <= '0;
                        rd_cnt   <= '0;
                        ctb_done <= 1'b1;
                     end else begin
                        rd_band <= nxt_band;
                        rd_sum  <= acc_sum[nxt_band];
                        rd_cnt  <= acc_cnt[nxt_band];
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
